alu_sequencer: RTL and testbench

Program-driven initiator for `alu_registers`: fetches 16-bit instructions from a synchronous instruction memory and issues one `ALUOp` command per instruction on the register-file command port. Read-back values are captured and presented on a result port. It replaces the hand-driven testbench stimulus as the control path in front of the register file. A start/busy/done handshake frames each program run.

---
 rtl/constants_pkg.sv | 12 +
 rtl/alu_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/constants_pkg.sv
// Shared command encoding for the register-file command port.
// NOP marks cycles in which the register file must take no action.
package constants_pkg;

    typedef enum logic [1:0] {
        ADD       = 2'd0,
        REG_WRITE = 2'd1,
        REG_READ  = 2'd2,
        NOP       = 2'd3
    } ALUOp;

endpackage

// File: rtl/alu_sequencer.sv
// Program-driven initiator for alu_registers: fetches 16-bit instructions from a
// synchronous memory and issues one register-file command per instruction.
module alu_sequencer
    import constants_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [2:0]        addr_a,
    output logic [2:0]        addr_b,
    output logic [2:0]        addr_r,
    output logic [7:0]        data_in,
    output ALUOp              op,
    input  logic [7:0]        reg_data,
    output logic              result_valid,
    output logic [2:0]        result_reg,
    output logic [7:0]        result_data
);

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

    localparam logic [3:0] OPC_NOP   = 4'h0;
    localparam logic [3:0] OPC_LOADI = 4'h1;
    localparam logic [3:0] OPC_ADD   = 4'h2;
    localparam logic [3:0] OPC_READ  = 4'h3;
    localparam logic [3:0] OPC_HALT  = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        RDWAIT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic              is_read;
    logic [2:0]        read_reg;

    logic [3:0] opcode;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] imm;
    logic       accept;
    logic       unused_bits;

    assign opcode      = imem_data[15:12];
    assign rd          = imem_data[10:8];
    assign ra          = imem_data[6:4];
    assign rb          = imem_data[2:0];
    assign imm         = imem_data[7:0];
    assign unused_bits = imem_data[11];

    // A start coinciding with the done pulse is held off until the following IDLE cycle.
    assign accept    = (state == IDLE) && start && !done;
    assign busy      = (state != IDLE);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OPC_NOP, OPC_LOADI, OPC_ADD, OPC_READ: state_next = EXEC;
                    default:                               state_next = IDLE;
                endcase
            end
            EXEC: begin
                state_next = is_read ? RDWAIT : FETCH;
            end
            RDWAIT: begin
                state_next = FETCH;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command outputs are registered in DECODE so they are valid for exactly the EXEC cycle;
    // addresses and data keep their last values while op returns to NOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= START_PC;
            is_read      <= 1'b0;
            read_reg     <= '0;
            op           <= NOP;
            addr_a       <= '0;
            addr_b       <= '0;
            addr_r       <= '0;
            data_in      <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            result_valid <= 1'b0;
            result_reg   <= '0;
            result_data  <= '0;
        end else begin
            done         <= 1'b0;
            result_valid <= 1'b0;
            op           <= NOP;
            case (state)
                IDLE: begin
                    if (accept) begin
                        pc    <= START_PC;
                        error <= 1'b0;
                    end
                end
                DECODE: begin
                    is_read  <= (opcode == OPC_READ);
                    read_reg <= ra;
                    case (opcode)
                        OPC_NOP: begin
                            op <= NOP;
                        end
                        OPC_LOADI: begin
                            addr_a  <= rd;
                            data_in <= imm;
                            op      <= REG_WRITE;
                        end
                        OPC_ADD: begin
                            addr_a <= ra;
                            addr_b <= rb;
                            addr_r <= rd;
                            op     <= ADD;
                        end
                        OPC_READ: begin
                            addr_a <= ra;
                            op     <= REG_READ;
                        end
                        OPC_HALT: begin
                            done <= 1'b1;
                        end
                        default: begin
                            done  <= 1'b1;
                            error <= 1'b1;
                        end
                    endcase
                end
                EXEC: begin
                    pc <= pc + ADDR_W'(1);
                end
                RDWAIT: begin
                    // reg_data reflects the REG_READ issued in the preceding EXEC cycle.
                    result_data  <= reg_data;
                    result_reg   <= read_reg;
                    result_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed programs plus random programs checked against
// an instruction-level interpreter; includes a behavioural register file and memories.
module tb_alu_sequencer;
    import constants_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset  = 1'b1;
    logic        start  = 1'b0;
    logic        start2 = 1'b0;

    logic        busy, done, error;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data = '0;
    logic [2:0]  addr_a, addr_b, addr_r;
    logic [7:0]  data_in;
    ALUOp        op;
    logic [7:0]  rf_out = '0;
    logic        result_valid;
    logic [2:0]  result_reg;
    logic [7:0]  result_data;

    logic        busy2, done2, error2;
    logic [3:0]  imem_addr2;
    logic [15:0] imem_data2 = '0;
    logic [2:0]  addr_a2, addr_b2, addr_r2;
    logic [7:0]  data_in2;
    ALUOp        op2;
    logic [7:0]  reg_data2 = 8'h00;
    logic        result_valid2;
    logic [2:0]  result_reg2;
    logic [7:0]  result_data2;

    alu_sequencer #(.ADDR_W(8), .START_ADDR(0)) u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .addr_a(addr_a), .addr_b(addr_b), .addr_r(addr_r), .data_in(data_in), .op(op),
        .reg_data(rf_out), .result_valid(result_valid), .result_reg(result_reg),
        .result_data(result_data)
    );

    alu_sequencer #(.ADDR_W(4), .START_ADDR(14)) u_wrap (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2), .error(error2),
        .imem_addr(imem_addr2), .imem_data(imem_data2),
        .addr_a(addr_a2), .addr_b(addr_b2), .addr_r(addr_r2), .data_in(data_in2), .op(op2),
        .reg_data(reg_data2), .result_valid(result_valid2), .result_reg(result_reg2),
        .result_data(result_data2)
    );

    logic [15:0] mem  [0:255];
    logic [15:0] mem2 [0:15];
    logic [7:0]  rf   [0:7];
    logic        rf_clear = 1'b1;

    always @(posedge clk) begin
        imem_data  <= mem[imem_addr];
        imem_data2 <= mem2[imem_addr2];
    end

    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            case (op)
                REG_WRITE: rf[addr_a] <= data_in;
                ADD:       rf[addr_r] <= rf[addr_a] + rf[addr_b];
                REG_READ:  rf_out     <= rf[addr_a];
                default: ;
            endcase
        end
    end

    int          compared   = 0;
    int          mismatched = 0;
    logic [7:0]  ref_rf [0:7];
    logic [10:0] exp_res[$];
    logic [10:0] got_res[$];
    int          exp_cycles, exp_cmds, got_cmds, done_cyc;
    logic        exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] enc_loadi(input logic [2:0] rd, input logic [7:0] imm);
        return {4'h1, 1'b0, rd, imm};
    endfunction
    function automatic logic [15:0] enc_add(input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
        return {4'h2, 1'b0, rd, 1'b0, ra, 1'b0, rb};
    endfunction
    function automatic logic [15:0] enc_read(input logic [2:0] ra);
        return {4'h3, 4'h0, 1'b0, ra, 4'h0};
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    // Interpreter: executes the program in mem from address 0 at instruction granularity.
    task automatic ref_run();
        int pc = 0;
        bit stop = 0;
        logic [15:0] w;
        exp_res.delete();
        exp_cycles = 0; exp_cmds = 0; exp_err = 1'b0;
        while (!stop) begin
            w = mem[pc];
            case (w[15:12])
                4'h0: exp_cycles += 3;
                4'h1: begin ref_rf[w[10:8]] = w[7:0]; exp_cycles += 3; exp_cmds++; end
                4'h2: begin ref_rf[w[10:8]] = ref_rf[w[6:4]] + ref_rf[w[2:0]]; exp_cycles += 3; exp_cmds++; end
                4'h3: begin exp_res.push_back({w[6:4], ref_rf[w[6:4]]}); exp_cycles += 4; exp_cmds++; end
                4'hF: begin exp_cycles += 2; stop = 1; end
                default: begin exp_cycles += 2; exp_err = 1'b1; stop = 1; end
            endcase
            pc = (pc + 1) % 256;
        end
    endtask

    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("launch_busy", busy, 1'b1);
        check("launch_err_clr", error, 1'b0);
        check("launch_imem_addr", imem_addr, 8'd0);
    endtask

    // Observes cycles 1.. after the accepted start; returns in the done cycle.
    task automatic monitor(input string tag, input int poke);
        got_res.delete();
        got_cmds = 0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            start = (cyc == poke);
            if (result_valid) got_res.push_back({result_reg, result_data});
            if (op != NOP) got_cmds++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, done_cyc, exp_cycles + 1);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_error"}, error, exp_err);
        check({tag, "_cmds"}, got_cmds, exp_cmds);
        check({tag, "_nresults"}, got_res.size(), exp_res.size());
        for (int i = 0; i < exp_res.size() && i < got_res.size(); i++)
            check($sformatf("%s_result%0d", tag, i), got_res[i], exp_res[i]);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_op"}, op, NOP);
        check({tag, "_addr_a"}, addr_a, 3'd0);
        check({tag, "_addr_b"}, addr_b, 3'd0);
        check({tag, "_addr_r"}, addr_r, 3'd0);
        check({tag, "_data_in"}, data_in, 8'd0);
        check({tag, "_imem_addr"}, imem_addr, 8'd0);
        check({tag, "_result_valid"}, result_valid, 1'b0);
        check({tag, "_result_reg"}, result_reg, 3'd0);
        check({tag, "_result_data"}, result_data, 8'd0);
    endtask

    initial begin
        logic [7:0] fib_exp [0:7];
        logic [3:0] wrap_seq[$];
        int len, found, cyc2, cmds2;
        logic [15:0] w;

        fib_exp = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h05, 8'h08, 8'h0D};
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;
        for (int i = 0; i < 16; i++) mem2[i] = 16'hF000;
        fill_mem();

        repeat (3) @(negedge clk);
        check_reset("rst");
        check("rst_wrap_imem_addr", imem_addr2, 4'd14);
        check("rst_wrap_busy", busy2, 1'b0);
        reset = 1'b0;
        rf_clear = 1'b0;

        // Basic sum, with a start pulse while busy that must be ignored.
        mem[0] = enc_loadi(3'd0, 8'h42);
        mem[1] = enc_loadi(3'd1, 8'h24);
        mem[2] = enc_add(3'd2, 3'd0, 3'd1);
        mem[3] = enc_read(3'd2);
        mem[4] = 16'hF000;
        ref_run();
        launch();
        monitor("sum", 5);
        check("sum_cycle_total", done_cyc, 16);
        if (got_res.size() > 0) check("sum_value", got_res[0], {3'd2, 8'h66});

        // Overflow, started on the cycle of the previous done (must be deferred one cycle).
        fill_mem();
        mem[0] = enc_loadi(3'd0, 8'hF0);
        mem[1] = enc_loadi(3'd1, 8'h20);
        mem[2] = enc_add(3'd2, 3'd0, 3'd1);
        mem[3] = enc_read(3'd2);
        ref_run();
        start = 1'b1;
        @(negedge clk);
        check("start_at_done_ignored", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("start_after_done_taken", busy, 1'b1);
        monitor("ovf", 0);
        if (got_res.size() > 0) check("ovf_value", got_res[0][7:0], 8'h10);

        // Fibonacci.
        fill_mem();
        mem[0] = enc_loadi(3'd0, 8'h00);
        mem[1] = enc_loadi(3'd1, 8'h01);
        mem[2] = enc_loadi(3'd2, 8'h01);
        for (int i = 3; i < 8; i++) mem[i] = enc_add(3'(i), 3'(i - 2), 3'(i - 1));
        for (int i = 0; i < 8; i++) mem[8 + i] = enc_read(3'(i));
        ref_run();
        launch();
        monitor("fib", 0);
        for (int i = 0; i < 8 && i < got_res.size(); i++)
            check($sformatf("fib_value%0d", i), got_res[i][7:0], fib_exp[i]);

        // Illegal opcode at address 1; error sticky until the next start.
        fill_mem();
        mem[0] = enc_loadi(3'd5, 8'h77);
        mem[1] = 16'h7000;
        ref_run();
        launch();
        monitor("ill", 0);
        check("ill_done_pulse", done, 1'b1);
        @(negedge clk);
        check("ill_error_sticky", error, 1'b1);
        check("ill_done_once", done, 1'b0);

        // Random programs, ending in HALT or an illegal opcode.
        for (int p = 0; p < 8; p++) begin
            fill_mem();
            len = $urandom_range(2, 10);
            for (int i = 0; i < len; i++) begin
                w = 16'($urandom);
                w[15:12] = 4'($urandom_range(0, 3));
                mem[i] = w;
            end
            w = 16'($urandom);
            w[15:12] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 14)) : 4'hF;
            mem[len] = w;
            ref_run();
            launch();
            monitor($sformatf("rnd%0d", p), $urandom_range(1, exp_cycles));
        end

        // Reset during EXEC of an ADD.
        fill_mem();
        mem[0] = enc_loadi(3'd0, 8'h11);
        mem[1] = enc_loadi(3'd1, 8'h22);
        mem[2] = enc_add(3'd2, 3'd0, 3'd1);
        mem[3] = enc_add(3'd3, 3'd0, 3'd1);
        launch();
        found = 0;
        for (int c = 0; c < 30; c++) begin
            if (op == ADD) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("rstmid_add_seen", found, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset("rstmid");
        reset = 1'b0;
        found = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || busy || op != NOP) found = 1;
        end
        check("rstmid_quiet_after", found, 0);

        // PC wrap on the narrow instance: 14, 15, 0.
        mem2[14] = enc_loadi(3'd1, 8'hAA);
        mem2[15] = enc_loadi(3'd2, 8'h55);
        mem2[0]  = 16'hF000;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc2 = -1;
        cmds2 = 0;
        for (int c = 1; c <= 50; c++) begin
            if (busy2 && (wrap_seq.size() == 0 || wrap_seq[$] != imem_addr2))
                wrap_seq.push_back(imem_addr2);
            if (op2 != NOP) cmds2++;
            if (done2) begin
                cyc2 = c;
                break;
            end
            @(negedge clk);
        end
        check("wrap_done_cycle", cyc2, 9);
        check("wrap_cmds", cmds2, 2);
        check("wrap_error", error2, 1'b0);
        check("wrap_seq_len", wrap_seq.size(), 3);
        if (wrap_seq.size() == 3) begin
            check("wrap_seq0", wrap_seq[0], 4'd14);
            check("wrap_seq1", wrap_seq[1], 4'd15);
            check("wrap_seq2", wrap_seq[2], 4'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
